// File: rtl/perim_feeder.sv
// Upstream feeder for the perimeter consumer: small (a,b) FIFO plus 4-phase dav_/rfd issuer.
// Optional rfd-edge timeout with sticky err is compiled in with `define PERIM_FEEDER_TIMEOUT_EN.
module perim_feeder #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset_,
    input  logic [3:0]               in_a,
    input  logic [3:0]               in_b,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [3:0]               a,
    output logic [3:0]               b,
    output logic                     dav_,
    input  logic                     rfd,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         sent,
    output logic                     err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1 || TIMEOUT < 1) begin : g_param_check
        $error("perim_feeder: DEPTH must be a power of 2 >= 2, CNT_W and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [3:0]         a_q, a_d;
    logic [3:0]         b_q, b_d;
    logic               dav_q, dav_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         head;
    logic               push;
    logic               pop;

`ifdef PERIM_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
`endif

    assign head     = mem_q[rd_ptr_q];
    assign in_ready = (level_q != LVL_W'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dav_d   = dav_q;
        sent_d  = sent_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                // Head is taken from the pre-edge FIFO, so a same-cycle push can never issue.
                if (level_q != '0 && rfd) begin
                    a_d     = head[7:4];
                    b_d     = head[3:0];
                    dav_d   = 1'b0;
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!rfd) begin
                    dav_d   = 1'b1;
                    pop     = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rfd) begin
                    sent_d  = sent_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                dav_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

`ifdef PERIM_FEEDER_TIMEOUT_EN
        err_d = err_q;
        tmo_d = '0;
        // Normal handshake progress wins; the timeout only fires while stuck in a wait state.
        if (state_q != IDLE && state_d == state_q) begin
            if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                dav_d   = 1'b1;
                pop     = (state_q == WAIT_LO);
                state_d = IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dav_q    <= 1'b1;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dav_q    <= dav_d;
            sent_q   <= sent_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

`ifdef PERIM_FEEDER_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset_) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign a     = a_q;
    assign b     = b_q;
    assign dav_  = dav_q;
    assign level = level_q;
    assign sent  = sent_q;

endmodule
